// File: rtl/accum_seq_pkg.sv
// Purpose: shared types and default sizes for the accumulator sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package accum_seq_pkg;

  localparam int ACC_WIDTH = 8;  // accumulator / step width
  localparam int ACC_CNT_W = 8;  // cycle-count width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } accum_seq_state_e;

endpackage

// File: rtl/accum_seq_ctrl_if.sv
// Purpose: groups the sequencer's request inputs and datapath-control outputs.
// Latency: n/a (wiring only).
// Backpressure: none; start is simply ignored while a run is in progress.
// master: requester/datapath side (drives start/step/n_cycles/abort/co).
// slave:  the sequencer (drives acc_clr/acc_en/step_q/busy/done/remaining/ovf).
interface accum_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic [WIDTH-1:0] step;
  logic [CNT_W-1:0] n_cycles;
  logic             abort;
  logic             co;
  logic             acc_clr;
  logic             acc_en;
  logic [WIDTH-1:0] step_q;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;
  logic             ovf;

  modport master (
    output start, step, n_cycles, abort, co,
    input  acc_clr, acc_en, step_q, busy, done, remaining, ovf
  );

  modport slave (
    input  start, step, n_cycles, abort, co,
    output acc_clr, acc_en, step_q, busy, done, remaining, ovf
  );
endinterface

// File: rtl/accum_seq_cnt.sv
// Purpose: loadable down-counter holding the accumulate cycles still to run.
// Latency: load/decrement visible one cycle after the edge; flags are from the count flop.
// Backpressure: none; decrement saturates at zero so the count never wraps.
// Ports: ck/clr clock and async active-low reset; load/load_val; dec; cnt, is_one, is_zero.
module accum_seq_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             ck,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one,
  output logic             is_zero
);

  always_ff @(posedge ck or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_one  = (cnt == CNT_W'(1));
  assign is_zero = (cnt == '0);

endmodule

// File: rtl/accum_seq_ctrl.sv
// Purpose: sequencer that clears the accumulator register, enables it for N cycles, then pulses done.
// Latency: start at edge k -> CLEAR cycle k+1, RUN k+2..k+1+N, done in k+2+N; all outputs registered.
// Backpressure: start ignored unless IDLE; abort (CLEAR/RUN) returns to IDLE without done.
// Ports: ck, clr (async active-low reset); bus (accum_seq_ctrl_if.slave) carries request and
// datapath signals. Optional ACC_OVF_STOP_EN: a carry seen during RUN ends the run with ovf=1.
module accum_seq_ctrl
  import accum_seq_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int CNT_W = ACC_CNT_W
) (
  input  logic             ck,
  input  logic             clr,
  accum_seq_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] CLEAR = ST_CLEAR;
  localparam logic [1:0] RUN   = ST_RUN;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]       state_q, state_d;
  logic             cnt_load, cnt_dec, cnt_is_one, cnt_is_zero;
  logic [CNT_W-1:0] cnt;
  logic             step_ld;
  logic             start_acc;
  logic             ovf_set;
  logic             acc_clr_q, acc_en_q, busy_q, done_q;
  logic [WIDTH-1:0] step_q;

  assign start_acc = (state_q == IDLE) && bus.start;

  accum_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .ck       (ck),
    .clr      (clr),
    .load     (cnt_load),
    .load_val (bus.n_cycles),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .is_one   (cnt_is_one),
    .is_zero  (cnt_is_zero)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    step_ld  = 1'b0;
    ovf_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // A zero-length run still reloads the counter so remaining reads 0 in DONE.
          cnt_load = 1'b1;
          if (bus.n_cycles != '0) begin
            step_ld = 1'b1;
            state_d = CLEAR;
          end else begin
            state_d = DONE;
          end
        end
      end
      CLEAR: begin
        state_d = bus.abort ? IDLE : RUN;
      end
      RUN: begin
        // The load in this cycle happens regardless, so the count always steps.
        cnt_dec = 1'b1;
        if (bus.abort) begin
          state_d = IDLE;
`ifdef ACC_OVF_STOP_EN
        end else if (bus.co) begin
          state_d = DONE;
          ovf_set = 1'b1;
`endif
        end else if (cnt_is_one || cnt_is_zero) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each one
  // changes together with the state flop and never follows an input directly.
  always_ff @(posedge ck or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      acc_clr_q <= 1'b1;
      acc_en_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      step_q    <= '0;
    end else begin
      state_q   <= state_d;
      acc_clr_q <= (state_d != CLEAR);
      acc_en_q  <= (state_d != RUN);
      busy_q    <= (state_d == CLEAR) || (state_d == RUN);
      done_q    <= (state_d == DONE);
      if (step_ld) begin
        step_q <= bus.step;
      end
    end
  end

`ifdef ACC_OVF_STOP_EN
  logic ovf_q;
  always_ff @(posedge ck or negedge clr) begin
    if (!clr) begin
      ovf_q <= 1'b0;
    end else if (start_acc) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end
  end
  assign bus.ovf = ovf_q;
`else
  logic unused_ovf_path;
  assign unused_ovf_path = bus.co ^ ovf_set ^ start_acc;
  assign bus.ovf = 1'b0;
`endif

  assign bus.acc_clr   = acc_clr_q;
  assign bus.acc_en    = acc_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.step_q    = step_q;
  assign bus.remaining = cnt;

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Purpose: self-checking bench for accum_seq_ctrl with an attached accumulator register model.
// Latency: checks every cycle of each run against a run-level reference model.
// Backpressure: exercises ignored mid-run start, abort, async reset and zero-length runs.
module tb_accum_seq_ctrl;
  import accum_seq_pkg::*;

  localparam int W = 8;
  localparam int C = 8;
`ifdef ACC_OVF_STOP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic ck;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  accum_seq_ctrl_if #(.WIDTH(W), .CNT_W(C)) bus ();

  accum_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
    .ck  (ck),
    .clr (clr),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Accumulator datapath: register with async active-low CLR and active-low EN,
  // fed by an adder of register + step_q whose carry goes back as co.
  logic [W-1:0] acc;
  logic [W:0]   sum;
  assign sum    = {1'b0, acc} + {1'b0, bus.step_q};
  assign bus.co = sum[W];
  always @(posedge ck or negedge bus.acc_clr) begin
    if (!bus.acc_clr) acc <= '0;
    else if (!bus.acc_en) acc <= sum[W-1:0];
  end

  logic [W-1:0] exp_step;   // what step_q should hold, tracked from stimulus
  logic         exp_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_acc_clr"}, 32'(bus.acc_clr), 32'd1);
    chk({tag, "_acc_en"},  32'(bus.acc_en), 32'd1);
    chk({tag, "_step_q"},  32'(bus.step_q), 32'd0);
    chk({tag, "_busy"},    32'(bus.busy), 32'd0);
    chk({tag, "_done"},    32'(bus.done), 32'd0);
    chk({tag, "_remain"},  32'(bus.remaining), 32'd0);
    chk({tag, "_ovf"},     32'(bus.ovf), 32'd0);
  endtask

  // One run. abort_at: 0 = no abort, k = assert abort in RUN cycle k.
  // mid_start: pulse start with a different step in RUN cycle 2.
  task automatic do_run(input logic [W-1:0] s, input logic [C-1:0] n,
                        input int abort_at, input bit mid_start);
    int kc, lim, loads;
    bit aborted, ovf_run;
    logic [W-1:0] acc_before;
    // Reference: the k-th load carries when k*s first reaches 2^W.
    kc      = (s == 0) ? 100000 : (256 + int'(s) - 1) / int'(s);
    lim     = int'(n);
    ovf_run = 1'b0;
    if (OVF_EN && kc <= int'(n)) begin
      lim     = kc;
      ovf_run = 1'b1;
    end
    aborted = (abort_at != 0) && (abort_at <= lim);
    loads   = aborted ? abort_at : lim;
    if (aborted) ovf_run = 1'b0;

    @(negedge ck);
    acc_before   = acc;
    bus.step     = s;
    bus.n_cycles = n;
    bus.start    = 1'b1;
    @(posedge ck);
    #1;
    bus.start    = 1'b0;
    bus.step     = W'($urandom);
    bus.n_cycles = C'($urandom);
    exp_ovf      = 1'b0;

    if (n == 0) begin
      @(negedge ck);
      chk("z_done",   32'(bus.done), 32'd1);
      chk("z_busy",   32'(bus.busy), 32'd0);
      chk("z_clr",    32'(bus.acc_clr), 32'd1);
      chk("z_en",     32'(bus.acc_en), 32'd1);
      chk("z_acc",    32'(acc), 32'(acc_before));
      chk("z_step_q", 32'(bus.step_q), 32'(exp_step));
      chk("z_remain", 32'(bus.remaining), 32'd0);
      chk("z_ovf",    32'(bus.ovf), 32'd0);
      @(negedge ck);
      chk("z_idle_done", 32'(bus.done), 32'd0);
      chk("z_idle_busy", 32'(bus.busy), 32'd0);
      return;
    end

    exp_step = s;
    @(negedge ck);
    chk("clr_acc_clr", 32'(bus.acc_clr), 32'd0);
    chk("clr_acc_en",  32'(bus.acc_en), 32'd1);
    chk("clr_busy",    32'(bus.busy), 32'd1);
    chk("clr_done",    32'(bus.done), 32'd0);
    chk("clr_step_q",  32'(bus.step_q), 32'(s));
    chk("clr_remain",  32'(bus.remaining), 32'(n));
    chk("clr_ovf",     32'(bus.ovf), 32'd0);

    for (int i = 1; i <= loads; i++) begin
      @(negedge ck);
      chk("run_acc_en",  32'(bus.acc_en), 32'd0);
      chk("run_acc_clr", 32'(bus.acc_clr), 32'd1);
      chk("run_busy",    32'(bus.busy), 32'd1);
      chk("run_done",    32'(bus.done), 32'd0);
      chk("run_step_q",  32'(bus.step_q), 32'(s));
      chk("run_remain",  32'(bus.remaining), 32'(int'(n) - i + 1));
      if (i == abort_at) bus.abort = 1'b1;
      if (mid_start && i == 2) begin
        bus.start = 1'b1;
        bus.step  = 8'h55;
      end
      @(posedge ck);
      #1;
      bus.abort = 1'b0;
      bus.start = 1'b0;
    end

    exp_ovf = ovf_run;
    @(negedge ck);
    chk("end_done",   32'(bus.done), aborted ? 32'd0 : 32'd1);
    chk("end_busy",   32'(bus.busy), 32'd0);
    chk("end_acc_en", 32'(bus.acc_en), 32'd1);
    chk("end_remain", 32'(bus.remaining), 32'(int'(n) - loads));
    chk("end_acc",    32'(acc), 32'((loads * int'(s)) % 256));
    chk("end_ovf",    32'(bus.ovf), 32'(exp_ovf));
    chk("end_step_q", 32'(bus.step_q), 32'(s));
    @(negedge ck);
    chk("idle_done",  32'(bus.done), 32'd0);
    chk("idle_busy",  32'(bus.busy), 32'd0);
    chk("idle_ovf",   32'(bus.ovf), 32'(exp_ovf));
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.step     = '0;
    bus.n_cycles = '0;
    bus.abort    = 1'b0;
    exp_step     = '0;
    exp_ovf      = 1'b0;
    clr          = 1'b0;
    repeat (2) @(negedge ck);
    chk_reset_vals("rst");
    clr = 1'b1;
    @(negedge ck);

    // Reset in the 3rd RUN cycle: outputs return immediately, without a clock edge.
    bus.step = 8'h01; bus.n_cycles = 8'd10; bus.start = 1'b1;
    @(posedge ck); #1; bus.start = 1'b0;
    repeat (4) @(negedge ck);   // CLEAR, RUN1, RUN2, RUN3
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #2 clr = 1'b0;
    #1 chk_reset_vals("mid_rst");
    exp_step = '0;
    @(negedge ck);
    clr = 1'b1;

    do_run(8'h03, 8'd5, 0, 1'b0);    // 5 loads of 3 -> 0x0F
    do_run(8'h07, 8'd0, 0, 1'b0);    // zero-length run
    do_run(8'h01, 8'd10, 3, 1'b0);   // abort in RUN3 -> 0x03, remaining 7
    do_run(8'h02, 8'd4, 0, 1'b1);    // mid-run start ignored -> 0x08
    do_run(8'h80, 8'd4, 0, 1'b0);    // carry on 2nd load
    do_run(8'h05, 8'd1, 1, 1'b0);    // abort beats last-cycle transition

    for (int r = 0; r < 10; r++) begin
      logic [W-1:0] s;
      logic [C-1:0] n;
      int a;
      s = W'($urandom);
      n = C'($urandom_range(0, 12));
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 13)) : 0;
      do_run(s, n, a, 1'(r % 3 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
